// File: rtl/seq_multiplier_if.sv
// Handshake and operand/result bundle between control and the shift-add multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;

  modport master (
    output start, A, B,
    input  busy, done, product_lo, product_hi
  );

  modport slave (
    input  start, A, B,
    output busy, done, product_lo, product_hi
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one ripple-carry add per cycle; WIDTH cycles per product.
// Serves MUL (product_lo) and UMULH (product_hi).
module seq_multiplier #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic             last_iter;

  // Ripple-carry adder; the carry-out lands in sum[WIDTH] and is shifted into the high half.
  always_comb begin
    logic carry;
    addend = acc_lo_q[0] ? mcand_q : '0;
    carry  = 1'b0;
    sum    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = acc_hi_q[i] ^ addend[i] ^ carry;
      carry  = (acc_hi_q[i] & addend[i]) | (carry & (acc_hi_q[i] ^ addend[i]));
    end
    sum[WIDTH] = carry;
  end

  assign accept    = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d  = StRun;
          mcand_d  = bus.A;
          acc_hi_d = '0;
          acc_lo_d = bus.B;
          count_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + 1'b1;
        if (last_iter) begin
          state_d   = StDone;
          prod_hi_d = sum[WIDTH:1];
          prod_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
    end
  end

  // Status decoded straight from state so reset clears it without a clock edge.
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.product_lo = prod_lo_q;
  assign bus.product_hi = prod_hi_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=64).
`timescale 1ns/1ps
module tb_seq_multiplier;

  localparam int unsigned W = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      step();
    end
  endtask

  initial begin
    int              cyc;
    int              n_done;
    logic [W-1:0]    vals [5];
    logic [2*W-1:0]  ref_p;

    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    vals[0] = 64'd0;
    vals[1] = 64'd1;
    vals[2] = 64'd2;
    vals[3] = 64'h8000_0000_0000_0000;
    vals[4] = 64'hFFFF_FFFF_FFFF_FFFF;

    #3;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_lo", bus.product_lo, 0);
    check_eq("rst_hi", bus.product_hi, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Basic 3*5
    issue(64'd3, 64'd5);
    check_eq("basic_busy_start", bus.busy, 1);
    wait_done(cyc);
    check_eq("basic_cycles", cyc, 64);
    check_eq("basic_done", bus.done, 1);
    check_eq("basic_lo", bus.product_lo, 15);
    check_eq("basic_hi", bus.product_hi, 0);
    step();
    check_eq("basic_idle_busy", bus.busy, 0);
    check_eq("basic_idle_done", bus.done, 0);
    check_eq("basic_hold_lo", bus.product_lo, 15);

    // All-ones: carry-out on every iteration
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(cyc);
    check_eq("ones_cycles", cyc, 64);
    check_eq("ones_hi", bus.product_hi, 128'hFFFF_FFFF_FFFF_FFFE);
    check_eq("ones_lo", bus.product_lo, 128'h1);
    step();

    // Zero operand with start/A/B disturbance during RUN
    issue(64'd0, 64'h1234);
    check_eq("zero_hold_lo_run", bus.product_lo, 1);
    cyc    = 0;
    n_done = 0;
    while (cyc < 200 && !bus.done) begin
      if (cyc == 10) begin
        bus.A     = 64'd5;
        bus.B     = 64'd5;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      cyc++;
      step();
    end
    bus.start = 1'b0;
    check_eq("zero_cycles", cyc, 64);
    check_eq("zero_done", bus.done, 1);
    check_eq("zero_lo", bus.product_lo, 0);
    check_eq("zero_hi", bus.product_hi, 0);
    for (int i = 0; i < 70; i++) begin
      step();
      if (bus.done) n_done++;
    end
    check_eq("zero_single_done", n_done, 0);
    check_eq("zero_idle", bus.busy, 0);

    // Back-to-back issue through the DONE cycle
    bus.A     = 64'd7;
    bus.B     = 64'd6;
    bus.start = 1'b1;
    step();
    wait_done(cyc);
    check_eq("b2b_cycles1", cyc, 64);
    check_eq("b2b_done1", bus.done, 1);
    check_eq("b2b_lo1", bus.product_lo, 42);
    bus.A = 64'h1_0000_0000;
    bus.B = 64'h1_0000_0000;
    step();
    bus.start = 1'b0;
    check_eq("b2b_no_gap", bus.busy, 1);
    wait_done(cyc);
    check_eq("b2b_cycles2", cyc, 64);
    check_eq("b2b_lo2", bus.product_lo, 0);
    check_eq("b2b_hi2", bus.product_hi, 1);
    step();

    // Asynchronous reset mid-operation
    issue(64'd9, 64'd9);
    for (int i = 0; i < 19; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_done", bus.done, 0);
    check_eq("arst_lo", bus.product_lo, 0);
    check_eq("arst_hi", bus.product_hi, 0);
    step();
    reset = 1'b0;
    step();
    issue(64'd10, 64'd10);
    wait_done(cyc);
    check_eq("arst_cycles", cyc, 64);
    check_eq("arst_lo100", bus.product_lo, 100);
    check_eq("arst_hi100", bus.product_hi, 0);
    step();

    // Sweep corner values against a 128-bit reference
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        ref_p = {64'd0, vals[i]} * {64'd0, vals[j]};
        issue(vals[i], vals[j]);
        wait_done(cyc);
        check_eq($sformatf("sweep_done_%0d_%0d", i, j), bus.done, 1);
        check_eq($sformatf("sweep_lo_%0d_%0d", i, j), bus.product_lo, ref_p[W-1:0]);
        check_eq($sformatf("sweep_hi_%0d_%0d", i, j), bus.product_hi, ref_p[2*W-1:W]);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle unsigned shift-add multiplier for the LEGv8 datapath; serves MUL (low half) and UMULH (high half).
- Sits directly downstream of the WIDTH-bit ripple adder chain: every iteration consumes one adder sum plus carry-out and registers it.
- Issued by control with a start/done handshake; the datapath stalls while busy is high.

Parameters:
- WIDTH, 64, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a multiply; sampled only in IDLE or DONE
- A  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge only
- B  input  WIDTH  multiplier, unsigned; sampled on the accepting edge only
- busy  output  1  high while an operation is in progress (state RUN)
- done  output  1  one-cycle pulse when the product is updated
- product_lo  output  WIDTH  low half of the last completed product (MUL)
- product_hi  output  WIDTH  high half of the last completed product (UMULH)

Behaviour:
- Reset is asynchronous and active-high. On assertion: state=IDLE, busy=0, done=0, product_lo=0, product_hi=0, all internal registers=0. This applies immediately, including mid-operation; the partial result is discarded.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at a rising edge accepts the request. Latch mcand=A, acc_hi=0, acc_lo=B, count=0, and go to RUN.
  - start=0 keeps the state in IDLE.
- RUN (busy=1), one iteration per cycle:
  - If acc_lo[0]=1, sum = acc_hi + mcand as WIDTH+1 bits (the carry-out is kept); otherwise sum = {1'b0, acc_hi}.
  - {acc_hi, acc_lo} <= {sum, acc_lo} >> 1, which shifts the carry into bit 2*WIDTH-1.
  - count increments each cycle. After the iteration with count=WIDTH-1, go to DONE and load product_hi=new acc_hi and product_lo=new acc_lo on that same edge.
  - start is ignored in RUN. A and B may change freely without effect.
- DONE (done=1, busy=0, one cycle):
  - product_lo/hi are valid.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back issue) and goes to RUN.
  - Otherwise go to IDLE.
- Latency: start is accepted at edge E0. RUN occupies WIDTH cycles. done is high in the cycle after edge E0+WIDTH. Issue-to-issue interval is WIDTH+1 cycles.
- product_lo/hi change only on the edge entering DONE (or on reset). They hold the previous result throughout RUN and IDLE.
- Arithmetic is unsigned modulo nothing: the full 2*WIDTH product is exact. The carry-out of every add must be captured; dropping it fails the all-ones case.
- Zero operands need no special path: the unit still takes WIDTH cycles and yields 0.
- Timing: the adder path is a WIDTH-bit ripple chain at 100ps per bit. The clock period for simulation is set by the bench and must exceed WIDTH*100ps plus register overhead.

Test Plan:
- Basic multiply: A=3, B=5, pulse start -> busy high for exactly 64 cycles; then done pulses 1 cycle with product_lo=15, product_hi=0; next cycle busy=0, done=0, products hold.
- All-ones: A=B=0xFFFF_FFFF_FFFF_FFFF -> product_hi=0xFFFF_FFFF_FFFF_FFFE, product_lo=0x0000_0000_0000_0001 (exercises the carry-out on every iteration).
- Busy and zero operands: A=0, B=0x1234 -> product 0 after the full 64-cycle latency. During RUN, change A/B and pulse start -> no effect, and done fires exactly once.
- Back-to-back issue: hold start=1 with A=7, B=6, then switch to A=2^32, B=2^32 in the DONE cycle -> first product_lo=42; second op accepted with no IDLE gap; second done 65 cycles later with product_lo=0, product_hi=1.
- Reset mid-operation: start A=9, B=9, assert reset at cycle 20 of RUN -> busy/done/product_lo/product_hi go to 0 without waiting for a clock edge. Release reset and issue A=10, B=10 -> product_lo=100 after 64 cycles.
- Sweep: A and B each over {0, 1, 2, 0x8000_0000_0000_0000, 0xFFFF_FFFF_FFFF_FFFF}, all 25 pairs -> every product matches the 128-bit reference computed in the bench.
